// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources.
// Optional macro UART_TX_ARBITER_LOCK_EN adds i_lock for back-to-back multi-byte messages.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_data,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]     i_lock,
`endif
  output logic [NUM_REQ-1:0]     o_ack,
  output logic [NUM_REQ-1:0]     o_err,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_busy,
  output logic                   o_active
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, START, SEND} state_e;

  state_e               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        win_q;
  logic [TW-1:0]        timer_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   err_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 start_q;
  logic [7:0]           data_q;
  logic                 active_q;

  logic                 arb_vld;
  logic [IW-1:0]        arb_idx;
  int unsigned          cand;
  logic                 lock_hit;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!arb_vld && i_req[IW'(cand)]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(cand);
      end
    end
  end

`ifdef UART_TX_ARBITER_LOCK_EN
  assign lock_hit = i_lock[win_q] & i_req[win_q];
`else
  assign lock_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      timer_q  <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      active_q <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: begin
          if (!i_tx_busy && arb_vld) begin
            win_q    <= arb_idx;
            grant_q  <= NUM_REQ'(1) << arb_idx;
            data_q   <= i_data[8*32'(arb_idx) +: 8];
            start_q  <= 1'b1;
            timer_q  <= '0;
            ptr_q    <= IW'((32'(arb_idx) + 1) % NUM_REQ);
            state_q  <= START;
            active_q <= 1'b1;
          end
        end
        // Busy rising wins over the timeout when both land on the same edge.
        START: begin
          if (i_tx_busy) begin
            start_q <= 1'b0;
            ack_q   <= NUM_REQ'(1) << win_q;
            state_q <= SEND;
          end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            start_q  <= 1'b0;
            err_q    <= NUM_REQ'(1) << win_q;
            grant_q  <= '0;
            state_q  <= IDLE;
            active_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        // Data stays put until the transmitter drops busy.
        SEND: begin
          if (!i_tx_busy) begin
            if (lock_hit) begin
              data_q  <= i_data[8*32'(win_q) +: 8];
              start_q <= 1'b1;
              timer_q <= '0;
              state_q <= START;
            end else begin
              grant_q  <= '0;
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack      = ack_q;
  assign o_err      = err_q;
  assign o_grant    = grant_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64); busy is driven by hand.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        busy;
  logic [3:0]  ack, err, grant;
  logic        start;
  logic [7:0]  txd;
  logic        active;
`ifdef UART_TX_ARBITER_LOCK_EN
  logic [3:0]  lock;
`endif

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_data     (data),
`ifdef UART_TX_ARBITER_LOCK_EN
    .i_lock     (lock),
`endif
    .o_ack      (ack),
    .o_err      (err),
    .o_grant    (grant),
    .o_tx_start (start),
    .o_tx_data  (txd),
    .i_tx_busy  (busy),
    .o_active   (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    busy = 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
    lock = '0;
`endif
    tick();
    tick();
    chk("rst_ack",    32'(ack),    32'h0);
    chk("rst_err",    32'(err),    32'h0);
    chk("rst_grant",  32'(grant),  32'h0);
    chk("rst_start",  32'(start),  32'h0);
    chk("rst_txd",    32'(txd),    32'h0);
    chk("rst_active", 32'(active), 32'h0);
    rst = 1'b0;

    // Single requester, busy rises 20 cycles after start and holds 100 cycles
    data = 32'h13A5_1110;
    req  = 4'b0100;
    tick();
    chk("s_grant",  32'(grant),  32'h4);
    chk("s_txd",    32'(txd),    32'hA5);
    chk("s_start",  32'(start),  32'h1);
    chk("s_active", 32'(active), 32'h1);
    chk("s_ack0",   32'(ack),    32'h0);
    for (int i = 1; i < 20; i++) begin
      tick();
      chk("s_start_hold", 32'(start), 32'h1);
    end
    busy = 1'b1;
    tick();
    chk("s_ack",     32'(ack),   32'h4);
    chk("s_start_lo",32'(start), 32'h0);
    chk("s_grant2",  32'(grant), 32'h4);
    req = 4'b0000;
    for (int i = 1; i < 100; i++) tick();
    chk("s_ack_pulse", 32'(ack),   32'h0);
    chk("s_txd_hold",  32'(txd),   32'hA5);
    chk("s_grant3",    32'(grant), 32'h4);
    busy = 1'b0;
    tick();
    chk("s_grant_end",  32'(grant),  32'h0);
    chk("s_active_end", 32'(active), 32'h0);
    chk("s_err",        32'(err),    32'h0);

    // Busy-blocked idle
    busy = 1'b1;
    req  = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_grant_blk",  32'(grant),  32'h0);
      chk("b_active_blk", 32'(active), 32'h0);
    end
    busy = 1'b0;
    tick();
    chk("b_grant", 32'(grant), 32'h2);
    chk("b_txd",   32'(txd),   32'h11);
    chk("b_start", 32'(start), 32'h1);
    busy = 1'b1;
    tick();
    chk("b_ack", 32'(ack), 32'h2);
    req = 4'b0000;

    // Reset while in SEND, between edges
    #3;
    rst = 1'b1;
    #1;
    chk("r_start",  32'(start),  32'h0);
    chk("r_grant",  32'(grant),  32'h0);
    chk("r_active", 32'(active), 32'h0);
    chk("r_ack",    32'(ack),    32'h0);
    #1;
    rst  = 1'b0;
    busy = 1'b0;
    req  = 4'b1001;
    tick();
    chk("r_grant0", 32'(grant), 32'h1);
    chk("r_txd0",   32'(txd),   32'h10);
    busy = 1'b1;
    tick();
    chk("r_ack0", 32'(ack), 32'h1);
    req  = 4'b0000;
    busy = 1'b0;
    tick();
    chk("r_idle", 32'(grant), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round robin with all requesters held
    data = 32'h1312_1110;
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'h1 << (i % 4));
      chk("rr_txd",   32'(txd),   32'h10 + 32'(i % 4));
      busy = 1'b1;
      tick();
      chk("rr_ack", 32'(ack), 32'h1 << (i % 4));
      busy = 1'b0;
      tick();
      chk("rr_idle", 32'(grant), 32'h0);
    end
    req = 4'b0000;

    // Timeout: busy never rises
    req = 4'b0001;
    tick();
    chk("t_grant", 32'(grant), 32'h1);
    chk("t_start", 32'(start), 32'h1);
    for (int k = 1; k < 64; k++) begin
      tick();
      chk("t_start_hold", 32'(start), 32'h1);
    end
    tick();
    chk("t_start_lo", 32'(start),  32'h0);
    chk("t_err",      32'(err),    32'h1);
    chk("t_ack",      32'(ack),    32'h0);
    chk("t_grant_lo", 32'(grant),  32'h0);
    chk("t_active",   32'(active), 32'h0);
    req = 4'b0000;
    tick();
    chk("t_err_pulse", 32'(err), 32'h0);

`ifdef UART_TX_ARBITER_LOCK_EN
    // Locked three-byte message from requester 1
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    lock = 4'b0010;
    data = 32'h0000_2100;
    req  = 4'b0010;
    tick();
    chk("l_grant1", 32'(grant), 32'h2);
    chk("l_txd1",   32'(txd),   32'h21);
    req  = 4'b0011;
    busy = 1'b1;
    tick();
    chk("l_ack1", 32'(ack), 32'h2);
    data = 32'h0000_2200;
    busy = 1'b0;
    tick();
    chk("l_grant2",  32'(grant),  32'h2);
    chk("l_start2",  32'(start),  32'h1);
    chk("l_txd2",    32'(txd),    32'h22);
    chk("l_active2", 32'(active), 32'h1);
    busy = 1'b1;
    tick();
    chk("l_ack2", 32'(ack), 32'h2);
    data = 32'h0000_2300;
    busy = 1'b0;
    tick();
    chk("l_grant3", 32'(grant), 32'h2);
    chk("l_txd3",   32'(txd),   32'h23);
    busy = 1'b1;
    tick();
    chk("l_ack3", 32'(ack), 32'h2);
    lock = 4'b0000;
    req  = 4'b0001;
    busy = 1'b0;
    tick();
    chk("l_idle",   32'(grant),  32'h0);
    chk("l_active", 32'(active), 32'h0);
    tick();
    chk("l_grant0", 32'(grant), 32'h1);
    chk("l_txd0",   32'(txd),   32'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares a single uart_tx transmitter among NUM_REQ byte-producing requesters using round-robin arbitration. It latches the winning requester's byte and drives the transmitter's start/data inputs. It sequences the uart_tx start/busy handshake and returns a per-requester acknowledge or timeout error. It sits between the on-chip byte sources (debug console, status reporter, etc.) and the uart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 32768, max i_clk cycles in START waiting for i_tx_busy to rise before aborting (must exceed 2 baud periods of uart_tx)

Ports:
i_clk  input  1  system clock (100 MHz)
i_rst  input  1  asynchronous, active-high reset
i_req  input  NUM_REQ  per-requester byte request, held until o_ack/o_err
i_data  input  8*NUM_REQ  per-requester byte, requester k on bits [8k+7:8k], stable while i_req[k]
o_ack  output  NUM_REQ  one-cycle pulse: byte accepted by transmitter
o_err  output  NUM_REQ  one-cycle pulse: start timeout, byte dropped
o_grant  output  NUM_REQ  one-hot current owner, zero when idle
o_tx_start  output  1  to uart_tx i_start
o_tx_data  output  8  to uart_tx i_data, registered
i_tx_busy  input  1  from uart_tx o_busy
o_active  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, all outputs cleared immediately): o_ack=0, o_err=0, o_grant=0, o_tx_start=0, o_tx_data=0, o_active=0, state=IDLE, rr pointer=0, timer=0.
- States: IDLE, START, SEND. All outputs registered.
- IDLE: if i_tx_busy==0 and |i_req, the winner is the first set i_req index searching from pointer upward with wrap. Next edge: o_grant=onehot(winner), o_tx_data=i_data[winner], o_tx_start=1, timer=0, pointer=(winner+1) mod NUM_REQ, go to START. If i_tx_busy==1 in IDLE, do not arbitrate.
- START: timer increments each cycle. On i_tx_busy==1: o_tx_start=0, o_ack[winner] pulses 1 cycle, go to SEND. Else if timer==TIMEOUT_CYCLES-1: o_tx_start=0, o_err[winner] pulses 1 cycle, o_grant=0, go to IDLE. Busy takes priority over timeout when both occur in the same cycle.
- SEND: o_tx_data is held stable. uart_tx samples data one baud after start, so the data must not change until busy falls. On i_tx_busy==0: o_grant=0, go to IDLE.
- Minimum gap: one IDLE cycle between bytes. Back-to-back transmission without busy falling is not supported (start is dropped on busy rise).
- Requester dropping i_req after grant: ignored, the byte is still sent and acked. Requester must deassert i_req or change i_data the cycle after o_ack, otherwise it re-arbitrates for a new byte.
- o_ack/o_err go only to the granted index and are never simultaneous.
- Fairness: with all requesters active, each gets exactly one byte per NUM_REQ grants.
- Mid-operation reset: o_tx_start drops asynchronously. uart_tx must share i_rst.

Optional Feature:
UART_TX_ARBITER_LOCK_EN
- With: adds input i_lock [NUM_REQ]. In SEND, on i_tx_busy==0, if i_lock[winner] && i_req[winner], the next edge re-grants the same winner directly (latches new i_data, o_tx_start=1, timer=0, go to START). Pointer is unchanged, o_grant stays asserted, and no IDLE cycle occurs. Used for atomic multi-byte messages.
- Without: the port is absent and every byte goes through IDLE arbitration.

Test Plan:
- Single requester: i_req=4'b0100, data[2]=8'hA5; bench uart model raises busy 20 cycles after start and holds it 100 cycles -> o_grant=4'b0100, o_tx_data=8'hA5, o_tx_start high for 20 cycles, one o_ack[2] pulse, then o_grant=0.
- Round-robin: i_req=4'b1111 held with data 8'h10..8'h13 -> grant order 0,1,2,3,0, with the o_tx_data sequence 10,11,12,13,10.
- Timeout: TIMEOUT_CYCLES=64, busy stuck 0, i_req=4'b0001 -> o_tx_start low after 64 START cycles, o_err[0] pulse, no o_ack, return to IDLE.
- Busy-blocked idle: i_tx_busy forced 1, i_req=4'b0010 -> no grant. Release busy -> grant to index 1 on the next edge.
- Reset mid-SEND: assert i_rst between clock edges -> o_tx_start, o_grant, o_active are 0 before the next edge. After release, pointer=0, and i_req=4'b1001 grants index 0.
- LOCK_EN: i_lock=4'b0010, i_req=4'b0011, 3 bytes from index 1 -> three consecutive grants to 1 with no IDLE gap, then index 0 is granted after i_lock[1] drops.
